// File: rtl/spi_rom_streamer_if.sv
// Host/flash-side bundle for spi_rom_streamer. The streamer itself is the SPI master;
// the slave view belongs to the host issuing requests and the flash answering on miso.
interface spi_rom_streamer_if #(
    parameter int ADDR_W = 24
);
    logic              start;
    logic [ADDR_W-1:0] start_addr;
    logic [21:0]       length;
    logic              spi_cs_n;
    logic              spi_sck;
    logic              spi_mosi;
    logic              spi_miso;
    logic [7:0]        out_data;
    logic              out_strobe;
    logic              busy;
    logic              done;

    modport master (
        input  start, start_addr, length, spi_miso,
        output spi_cs_n, spi_sck, spi_mosi, out_data, out_strobe, busy, done
    );

    modport slave (
        output start, start_addr, length, spi_miso,
        input  spi_cs_n, spi_sck, spi_mosi, out_data, out_strobe, busy, done
    );
endinterface

// File: rtl/spi_rom_streamer.sv
// Streams a ROM image out of SPI NOR flash (mode 0) as one strobed byte per transfer.
// Define SPI_FASTREAD_EN for FAST_READ (0x0B) with 8 dummy clocks; default is READ (0x03).
module spi_rom_streamer #(
    parameter int CLK_DIV = 2,
    parameter int ADDR_W  = 24
) (
    input  logic clk,
    input  logic reset,
    spi_rom_streamer_if.master bus
);
    localparam int               DIV_W     = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST  = DIV_W'(CLK_DIV - 1);
    localparam int               TX_W      = 8 + ADDR_W;
    localparam logic [4:0]       ADDR_LAST = 5'(ADDR_W - 1);
`ifdef SPI_FASTREAD_EN
    localparam logic [7:0]       READ_CMD  = 8'h0B;
`else
    localparam logic [7:0]       READ_CMD  = 8'h03;
`endif

    typedef enum logic [2:0] {IDLE, CMD, ADDR, DUMMY, DATA} state_t;

    state_t           state;
    logic [DIV_W-1:0] div;
    logic [4:0]       bit_cnt;
    logic [21:0]      remain;
    logic [TX_W-1:0]  tx_sr;
    logic [7:0]       rx_sr;
    logic             cs_n_q;
    logic             sck_q;
    logic             mosi_q;
    logic [7:0]       data_q;
    logic             strobe_q;
    logic             busy_q;
    logic             done_q;

    assign bus.spi_cs_n   = cs_n_q;
    assign bus.spi_sck    = sck_q;
    assign bus.spi_mosi   = mosi_q;
    assign bus.out_data   = data_q;
    assign bus.out_strobe = strobe_q;
    assign bus.busy       = busy_q;
    assign bus.done       = done_q;

    always_ff @(posedge clk) begin
        strobe_q <= 1'b0;
        done_q   <= 1'b0;
        if (reset) begin
            state   <= IDLE;
            cs_n_q  <= 1'b1;
            sck_q   <= 1'b0;
            mosi_q  <= 1'b0;
            data_q  <= 8'h00;
            busy_q  <= 1'b0;
            div     <= '0;
            bit_cnt <= '0;
            remain  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        if (bus.length == 22'd0) begin
                            done_q <= 1'b1;
                        end else begin
                            remain  <= bus.length;
                            tx_sr   <= {READ_CMD, bus.start_addr};
                            cs_n_q  <= 1'b0;
                            mosi_q  <= READ_CMD[7];
                            busy_q  <= 1'b1;
                            sck_q   <= 1'b0;
                            div     <= '0;
                            bit_cnt <= '0;
                            state   <= CMD;
                        end
                    end
                end
                default: begin
                    if (div != DIV_LAST) begin
                        div <= div + DIV_W'(1);
                    end else begin
                        div   <= '0;
                        sck_q <= ~sck_q;
                        if (!sck_q) begin
                            // Rising sck: flash has held miso stable since the previous fall.
                            if (state == DATA)
                                rx_sr <= {rx_sr[6:0], bus.spi_miso};
                        end else begin
                            // Falling sck closes a bit: advance phase and present the next mosi bit.
                            bit_cnt <= bit_cnt + 5'd1;
                            case (state)
                                CMD: begin
                                    mosi_q <= tx_sr[TX_W-2];
                                    tx_sr  <= tx_sr << 1;
                                    if (bit_cnt == 5'd7) begin
                                        bit_cnt <= '0;
                                        state   <= ADDR;
                                    end
                                end
                                ADDR: begin
                                    if (bit_cnt == ADDR_LAST) begin
                                        bit_cnt <= '0;
                                        mosi_q  <= 1'b0;
`ifdef SPI_FASTREAD_EN
                                        state   <= DUMMY;
`else
                                        state   <= DATA;
`endif
                                    end else begin
                                        mosi_q <= tx_sr[TX_W-2];
                                        tx_sr  <= tx_sr << 1;
                                    end
                                end
                                DUMMY: begin
                                    if (bit_cnt == 5'd7) begin
                                        bit_cnt <= '0;
                                        state   <= DATA;
                                    end
                                end
                                DATA: begin
                                    if (bit_cnt == 5'd7) begin
                                        bit_cnt  <= '0;
                                        data_q   <= rx_sr;
                                        strobe_q <= 1'b1;
                                        remain   <= remain - 22'd1;
                                        if (remain == 22'd1) begin
                                            state  <= IDLE;
                                            cs_n_q <= 1'b1;
                                            busy_q <= 1'b0;
                                            done_q <= 1'b1;
                                        end
                                    end
                                end
                                default: state <= IDLE;
                            endcase
                        end
                    end
                end
            endcase
        end
    end
endmodule

// File: tb/tb_spi_rom_streamer.sv
// Randomised bench for spi_rom_streamer: a behavioural SPI flash answers the bus and
// every streamed byte is compared against the flash image at the requested address.
`timescale 1ns/1ps
module tb_spi_rom_streamer;
    localparam int CLK_DIV = 2;
`ifdef SPI_FASTREAD_EN
    localparam int         DUMMY_BITS = 8;
    localparam logic [7:0] EXP_CMD    = 8'h0B;
`else
    localparam int         DUMMY_BITS = 0;
    localparam logic [7:0] EXP_CMD    = 8'h03;
`endif
    // One SPI bit is 2*CLK_DIV clks; a byte is 16*CLK_DIV.
    localparam int FIRST_LAT = (32 * 2 * CLK_DIV) + 16 * CLK_DIV + DUMMY_BITS * 2 * CLK_DIV;
    localparam int GAP       = 16 * CLK_DIV;

    logic clk = 1'b0;
    logic reset;
    int   n_checks = 0;
    int   n_fail   = 0;

    logic [7:0]  mem [0:4095];
    logic [31:0] fl_hdr;
    int          fl_bits    = 0;
    int          fl_selects = 0;

    spi_rom_streamer_if #(.ADDR_W(24)) bus ();

    spi_rom_streamer #(.CLK_DIV(CLK_DIV), .ADDR_W(24)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
        end
    endtask

    // Flash: shifts in cmd+addr on sck rises, drives image bytes MSB first after each fall.
    initial begin : flash_model
        logic        prev_sck;
        logic        prev_cs;
        int          k;
        logic [23:0] a;
        prev_sck     = 1'b0;
        prev_cs      = 1'b1;
        fl_hdr       = '0;
        bus.spi_miso = 1'b0;
        forever begin
            @(negedge clk);
            if (prev_cs === 1'b1 && bus.spi_cs_n === 1'b0) begin
                fl_bits = 0;
                fl_hdr  = '0;
                fl_selects++;
            end else if (bus.spi_cs_n === 1'b0) begin
                if (prev_sck === 1'b0 && bus.spi_sck === 1'b1) begin
                    if (fl_bits < 32) fl_hdr = {fl_hdr[30:0], bus.spi_mosi};
                    fl_bits++;
                end else if (prev_sck === 1'b1 && bus.spi_sck === 1'b0 && fl_bits >= 32 + DUMMY_BITS) begin
                    k = fl_bits - 32 - DUMMY_BITS;
                    a = fl_hdr[23:0] + 24'(k / 8);
                    bus.spi_miso = mem[a[11:0]][7 - (k % 8)];
                end
            end
            prev_sck = bus.spi_sck;
            prev_cs  = bus.spi_cs_n;
        end
    end

    task automatic run_xfer(input logic [23:0] addr, input logic [21:0] len, input int poke_at);
        int          cyc;
        int          nstrb;
        int          last_cyc;
        int          viol;
        int          budget;
        bit          got_done;
        bit          poked;
        logic [23:0] a;
        bus.start      = 1'b1;
        bus.start_addr = addr;
        bus.length     = len;
        @(negedge clk);
        bus.start = 1'b0;
        cyc = 0; nstrb = 0; last_cyc = 0; viol = 0; got_done = 0; poked = 0;
        budget = FIRST_LAT + GAP * int'(len) + 20;
        check_val("start_busy", 32'(bus.busy), 32'd1);
        check_val("start_cs_n", 32'(bus.spi_cs_n), 32'd0);
        check_val("done_pulse_width", 32'(bus.done), 32'd0);
        while (!got_done && cyc < budget) begin
            @(negedge clk);
            cyc++;
            bus.start = 1'b0;
            if (bus.out_strobe) begin
                a = addr + 24'(nstrb);
                check_val("data", 32'(bus.out_data), 32'(mem[a[11:0]]));
                if (nstrb == 0) check_val("first_latency", cyc, FIRST_LAT);
                else            check_val("strobe_gap", cyc - last_cyc, GAP);
                last_cyc = cyc;
                nstrb++;
                if (nstrb == poke_at && nstrb < int'(len) && !poked) begin
                    bus.start      = 1'b1;
                    bus.start_addr = ~addr;
                    bus.length     = 22'd9;
                    poked          = 1;
                end
            end
            if (bus.done) begin
                got_done = 1;
                check_val("done_with_last", cyc, last_cyc);
                check_val("end_cs_n", 32'(bus.spi_cs_n), 32'd1);
                check_val("end_sck", 32'(bus.spi_sck), 32'd0);
                check_val("end_busy", 32'(bus.busy), 32'd0);
            end else if (bus.busy !== 1'b1 || bus.spi_cs_n !== 1'b0) begin
                viol++;
            end
        end
        bus.start = 1'b0;
        check_val("got_done", 32'(got_done), 32'd1);
        check_val("n_strobes", nstrb, int'(len));
        check_val("busy_cs_hold", viol, 0);
        check_val("cmd", 32'(fl_hdr[31:24]), 32'(EXP_CMD));
        check_val("addr", 32'(fl_hdr[23:0]), 32'(addr));
        check_val("sck_count", fl_bits, 32 + DUMMY_BITS + 8 * int'(len));
    endtask

    task automatic run_empty();
        int sel0;
        int ndone;
        int nact;
        sel0 = fl_selects;
        bus.start      = 1'b1;
        bus.start_addr = 24'($urandom);
        bus.length     = 22'd0;
        @(negedge clk);
        bus.start = 1'b0;
        check_val("empty_done", 32'(bus.done), 32'd1);
        check_val("empty_busy", 32'(bus.busy), 32'd0);
        check_val("empty_cs_n", 32'(bus.spi_cs_n), 32'd1);
        ndone = 0; nact = 0;
        repeat (20) begin
            @(negedge clk);
            if (bus.done) ndone++;
            if (bus.busy || !bus.spi_cs_n) nact++;
        end
        check_val("empty_done_once", ndone, 0);
        check_val("empty_idle", nact, 0);
        check_val("empty_no_select", fl_selects, sel0);
    endtask

    task automatic reset_mid();
        int cyc;
        int nstrb;
        int after;
        bus.start      = 1'b1;
        bus.start_addr = 24'h000100;
        bus.length     = 22'd8;
        @(negedge clk);
        bus.start = 1'b0;
        cyc = 0; nstrb = 0;
        while (nstrb < 3 && cyc < FIRST_LAT + 3 * GAP + 20) begin
            @(negedge clk);
            cyc++;
            if (bus.out_strobe) nstrb++;
        end
        check_val("rst_mid_reached", nstrb, 3);
        repeat (GAP / 2) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        check_val("rst_mid_cs_n", 32'(bus.spi_cs_n), 32'd1);
        check_val("rst_mid_sck", 32'(bus.spi_sck), 32'd0);
        check_val("rst_mid_busy", 32'(bus.busy), 32'd0);
        check_val("rst_mid_strobe", 32'(bus.out_strobe), 32'd0);
        check_val("rst_mid_data", 32'(bus.out_data), 32'd0);
        reset = 1'b0;
        after = 0;
        repeat (4 * GAP) begin
            @(negedge clk);
            if (bus.out_strobe || bus.done || bus.busy || !bus.spi_cs_n) after++;
        end
        check_val("rst_mid_quiet", after, 0);
    endtask

    initial begin : watchdog
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish, checks=%0d", n_checks);
        $fatal(1, "watchdog expired");
    end

    initial begin : main
        logic [23:0] a;
        logic [21:0] l;
        reset          = 1'b1;
        bus.start      = 1'b0;
        bus.start_addr = '0;
        bus.length     = '0;
        for (int i = 0; i < 4096; i++) mem[i] = 8'($urandom);
        mem[16] = 8'h4E; mem[17] = 8'h45; mem[18] = 8'h53; mem[19] = 8'h1A;

        repeat (3) @(negedge clk);
        check_val("reset_cs_n", 32'(bus.spi_cs_n), 32'd1);
        check_val("reset_sck", 32'(bus.spi_sck), 32'd0);
        check_val("reset_mosi", 32'(bus.spi_mosi), 32'd0);
        check_val("reset_data", 32'(bus.out_data), 32'd0);
        check_val("reset_strobe", 32'(bus.out_strobe), 32'd0);
        check_val("reset_busy", 32'(bus.busy), 32'd0);
        check_val("reset_done", 32'(bus.done), 32'd0);
        reset = 1'b0;
        @(negedge clk);

        run_xfer(24'h000010, 22'd4, -1);
        run_xfer(24'h000010, 22'd4, 2);
        run_empty();
        reset_mid();
        run_xfer(24'hFFFFFE, 22'd4, -1);

        for (int t = 0; t < 10; t++) begin
            a = 24'($urandom);
            l = 22'($urandom_range(1, 5));
            run_xfer(a, l, (t % 4 == 1) ? 1 : -1);
            repeat ($urandom_range(0, 3)) @(negedge clk);
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule
